// File: rtl/slave_read_tx.sv
// Serialises one slave read word onto slave_tx: a start bit, then the data LSB first, then a DONE cycle.
// A request whose rd_valid does not arrive within TIMEOUT WAIT cycles is abandoned and reported on tx_err.
module slave_read_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_valid,
  output logic                  slave_tx,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_err
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, DONE} state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bit_cnt;
  logic [TW-1:0]         to_cnt;
  logic                  err_q;
  logic                  last_bit;
  logic                  last_wait;

  assign last_bit  = (bit_cnt == CW'(DATA_WIDTH - 1));
  assign last_wait = (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (rd_en) next_state = WAIT;
      WAIT: begin
        if (rd_valid)       next_state = START;
        else if (last_wait) next_state = IDLE;
      end
      START: next_state = DATA;
      DATA:  if (last_bit) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // tx_err is a registered flag so it can pulse in the IDLE cycle that follows a timeout.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg   <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= (state == WAIT) && !rd_valid && last_wait;
      case (state)
        IDLE: if (rd_en) to_cnt <= '0;
        WAIT: begin
          if (rd_valid) begin
            shreg   <= rd_data;
            bit_cnt <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DATA: begin
          shreg <= shreg >> 1;
          if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    slave_tx = 1'b0;
    tx_busy  = (state != IDLE);
    tx_done  = (state == DONE);
    tx_err   = err_q;
    case (state)
      START:   slave_tx = 1'b1;
      DATA:    slave_tx = shreg[0];
      default: slave_tx = 1'b0;
    endcase
  end

endmodule

// File: doc/slave_read_tx.md
SLAVE_READ_TX -- requirements
Module: slave_read_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of one read data word.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of WAIT cycles allowed before rd_valid arrives.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port rd_en, input, 1 bit: one-cycle read request from the slave controller.
REQ-006 The block SHALL have port rd_data, input, DATA_WIDTH bits: parallel read word from slave storage.
REQ-007 The block SHALL have port rd_valid, input, 1 bit: rd_data is valid this cycle.
REQ-008 The block SHALL have port slave_tx, output, 1 bit: serial read-data line returned toward the master receive path.
REQ-009 The block SHALL have port tx_busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port tx_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-011 The block SHALL have port tx_err, output, 1 bit: one-cycle pulse when the rd_valid timeout expires.

Function
REQ-012 The block SHALL implement a Moore FSM with states IDLE, WAIT, START, DATA and DONE; all outputs SHALL decode from registered state only.
REQ-013 In IDLE, rd_en=1 SHALL move the FSM to WAIT and clear the timeout counter; rd_valid SHALL be ignored in IDLE.
REQ-014 rd_en SHALL be ignored in every state except IDLE; no request is queued.
REQ-015 In WAIT, rd_valid=1 SHALL capture rd_data into the shift register, clear the bit counter and move the FSM to START.
REQ-016 In WAIT, with rd_valid=0, the timeout counter SHALL increment; when it reaches TIMEOUT-1 with rd_valid=0, the FSM SHALL move to IDLE and tx_err SHALL pulse high for exactly the next cycle.
REQ-017 rd_valid=1 on the final permitted WAIT cycle SHALL win over the timeout: the word is captured and tx_err stays low.
REQ-018 The START state SHALL last one cycle, with slave_tx=1 (start bit).
REQ-019 The DATA state SHALL last exactly DATA_WIDTH cycles and send the captured word LSB first, one bit per cycle; slave_tx SHALL equal shift register bit 0, and the register SHALL shift right each cycle.
REQ-020 The bit counter SHALL be $clog2(DATA_WIDTH) bits wide and SHALL NOT wrap before the last bit; after bit DATA_WIDTH-1 the FSM SHALL go to DONE.
REQ-021 The DONE state SHALL last one cycle with tx_done=1 and slave_tx=0, then return to IDLE.
REQ-022 slave_tx SHALL be 0 in IDLE, WAIT and DONE, so the line idles low.
REQ-023 Latency SHALL be fixed: if rd_valid is sampled in WAIT at cycle N, the start bit appears at N+1, bit i at N+2+i, and tx_done at N+2+DATA_WIDTH.
REQ-024 Changes on rd_data after capture SHALL NOT affect the frame in progress.
REQ-025 tx_done and tx_err SHALL never be high in the same cycle.

Reset
REQ-026 On a clock edge with rstn=0, the FSM SHALL go to IDLE and the shift register, bit counter and timeout counter SHALL clear to 0.
REQ-027 After reset, slave_tx, tx_busy, tx_done and tx_err SHALL all be 0.
REQ-028 Reset in any state, including mid-frame, SHALL abort the frame immediately with no tx_done or tx_err pulse; rd_en in the first cycle after reset release SHALL be accepted.

Verification
REQ-029 Scenario 1: rd_en, then rd_valid with rd_data=8'hA5 one cycle later -> slave_tx sequence 1,1,0,1,0,0,1,0,1, then tx_done=1 at N+10 and tx_busy low the following cycle.
REQ-030 Scenario 2: rd_en, then rd_valid withheld for 16 cycles -> tx_err pulses once, FSM returns to IDLE, slave_tx stays 0 throughout.
REQ-031 Scenario 3: rd_valid asserted on the 16th WAIT cycle with rd_data=8'h01 -> no tx_err; frame 1,1,0,0,0,0,0,0,0; tx_done asserted.
REQ-032 Scenario 4: rd_en pulses during DATA, and rd_data changes to 8'hFF after capture of 8'h3C -> frame still carries 8'h3C and no second frame follows.
REQ-033 Scenario 5: rstn=0 during bit 4 of a frame -> next cycle all outputs 0 and no tx_done; a new rd_en immediately after release completes a normal frame.
REQ-034 Scenario 6: rd_en and rd_valid asserted together in IDLE with rd_data=8'hFF -> rd_valid ignored; FSM enters WAIT and waits for a later rd_valid.
